// File: rtl/freelist_alloc.sv
// Physical-register free list for a 4-wide rename stage: up to 4 allocations and 4 frees per cycle,
// with a single-level head checkpoint for mispredict recovery.
module freelist_alloc #(
    parameter int unsigned PWIDTH = 6,
    parameter int unsigned ARCH   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    input  logic [3:0]            i_req_mask,
    output logic                  o_grant,
    output logic [4*PWIDTH-1:0]   o_tags4x,
    input  logic [3:0]            i_free_mask,
    input  logic [4*PWIDTH-1:0]   i_free_tags4x,
    input  logic                  i_save_en,
    input  logic                  i_return,
    output logic                  o_busy,
    output logic [PWIDTH:0]       o_count,
    output logic                  o_err
);

    localparam int unsigned DEPTH = (2 ** PWIDTH) - ARCH;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PWIDTH + 1;
    localparam int unsigned SUM_W = PWIDTH + 2;

    logic [PWIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  saved_head;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  alloc_since_save;
    logic              busy;
    logic              err;

    logic [2:0]        req_n;
    logic [2:0]        acc_r;
    logic [2:0]        acc_f;
    logic              grant_c;
    logic              busy_return;
    logic              err_set;
    logic [SUM_W-1:0]  cnt_base;
    logic [3:0]        wr_en;
    logic [PTR_W-1:0]  wr_idx [4];
    logic [PWIDTH-1:0] wr_tag [4];
    logic [PTR_W-1:0]  head_next;

    // Pointer advance that wraps at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr, input logic [2:0] off);
        logic [PTR_W:0] s;
        s = {1'b0, ptr} + (PTR_W+1)'(off);
        if (s >= (PTR_W+1)'(DEPTH)) begin
            s = s - (PTR_W+1)'(DEPTH);
        end
        return s[PTR_W-1:0];
    endfunction

    function automatic logic [2:0] pop4(input logic [3:0] m);
        return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

    always_comb begin
        req_n       = pop4(i_req_mask);
        grant_c     = i_req_valid & ~i_return & (count >= CNT_W'(req_n));
        busy_return = i_return & busy;
        acc_r       = 3'd0;
        acc_f       = 3'd0;
        err_set     = 1'b0;
        wr_en       = 4'b0000;
        o_tags4x    = '0;

        // Lanes read consecutive entries from head, skipping lanes without a request.
        for (int k = 0; k < 4; k++) begin
            o_tags4x[k*PWIDTH +: PWIDTH] = mem[wrap_add(head, acc_r)];
            if (i_req_mask[k]) begin
                acc_r = acc_r + 3'd1;
            end
        end

        if (busy_return) begin
            cnt_base = SUM_W'(count) + SUM_W'(alloc_since_save);
        end else if (grant_c) begin
            cnt_base = SUM_W'(count) - SUM_W'(req_n);
        end else begin
            cnt_base = SUM_W'(count);
        end

        // Frees are compacted at tail; an illegal tag or one that would overfill the list is dropped.
        for (int k = 0; k < 4; k++) begin
            wr_tag[k] = i_free_tags4x[k*PWIDTH +: PWIDTH];
            wr_idx[k] = wrap_add(tail, acc_f);
            if (i_free_mask[k]) begin
                if ((wr_tag[k] < PWIDTH'(ARCH)) ||
                    ((cnt_base + SUM_W'(acc_f) + SUM_W'(1)) > SUM_W'(DEPTH))) begin
                    err_set = 1'b1;
                end else begin
                    wr_en[k] = 1'b1;
                    acc_f    = acc_f + 3'd1;
                end
            end
        end

        if (busy_return) begin
            head_next = saved_head;
        end else if (grant_c) begin
            head_next = wrap_add(head, req_n);
        end else begin
            head_next = head;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[PTR_W'(i)] <= PWIDTH'(ARCH + i);
            end
            head             <= '0;
            tail             <= '0;
            saved_head       <= '0;
            count            <= CNT_W'(DEPTH);
            alloc_since_save <= '0;
            busy             <= 1'b0;
            err              <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (wr_en[k]) begin
                    mem[wr_idx[k]] <= wr_tag[k];
                end
            end
            head  <= head_next;
            tail  <= wrap_add(tail, acc_f);
            count <= CNT_W'(cnt_base + SUM_W'(acc_f));
            if (err_set) begin
                err <= 1'b1;
            end
            // Checkpoint marks the head after this cycle's grant; return wins over save.
            if (busy_return) begin
                busy             <= 1'b0;
                alloc_since_save <= '0;
            end else if (i_save_en && !i_return) begin
                busy             <= 1'b1;
                saved_head       <= head_next;
                alloc_since_save <= '0;
            end else if (busy && grant_c) begin
                alloc_since_save <= alloc_since_save + CNT_W'(req_n);
            end
        end
    end

    assign o_grant = grant_c;
    assign o_busy  = busy;
    assign o_count = count;
    assign o_err   = err;

endmodule

// File: tb/tb_freelist_alloc.sv
// Directed bench for freelist_alloc (PWIDTH=6, ARCH=32, DEPTH=32).
module tb_freelist_alloc;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [3:0]  mask;
    logic        grant;
    logic [23:0] tags;
    logic [3:0]  fmask;
    logic [23:0] ftags;
    logic        save;
    logic        ret;
    logic        busy;
    logic [6:0]  count;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    freelist_alloc #(.PWIDTH(6), .ARCH(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .i_req_mask(mask),
        .o_grant(grant), .o_tags4x(tags), .i_free_mask(fmask), .i_free_tags4x(ftags),
        .i_save_en(save), .i_return(ret), .o_busy(busy), .o_count(count), .o_err(err)
    );

    function automatic logic [5:0] lane(input logic [23:0] v, input int k);
        return v[k*6 +: 6];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid = 1'b0; mask = 4'b0000; fmask = 4'b0000; ftags = '0; save = 1'b0; ret = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 7'd32) begin errors++; $display("FAIL reset_count got %0d want 32", count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL reset_grant_idle got %b want 0", grant); end
    endtask

    task automatic test_alloc();
        valid = 1'b1; mask = 4'b1111; #1;
        checks++; if (grant !== 1'b1) begin errors++; $display("FAIL alloc4_grant got %b want 1", grant); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (lane(tags, k) !== 6'(32 + k)) begin
                errors++; $display("FAIL alloc4_lane%0d got %0d want %0d", k, lane(tags, k), 32 + k);
            end
        end
        tick();
        mask = 4'b1010;
        checks++; if (count !== 7'd28) begin errors++; $display("FAIL alloc4_count got %0d want 28", count); end
        #1;
        checks++; if (grant !== 1'b1) begin errors++; $display("FAIL sparse_grant got %b want 1", grant); end
        checks++; if (lane(tags, 1) !== 6'd36) begin errors++; $display("FAIL sparse_lane1 got %0d want 36", lane(tags, 1)); end
        checks++; if (lane(tags, 3) !== 6'd37) begin errors++; $display("FAIL sparse_lane3 got %0d want 37", lane(tags, 3)); end
        tick();
        idle();
        checks++; if (count !== 7'd26) begin errors++; $display("FAIL sparse_count got %0d want 26", count); end
    endtask

    task automatic test_full();
        do_reset();
        valid = 1'b1; mask = 4'b1111;
        repeat (7) tick();
        mask = 4'b0011;
        tick();
        idle();
        checks++; if (count !== 7'd2) begin errors++; $display("FAIL drain_count got %0d want 2", count); end
        valid = 1'b1; mask = 4'b0111; fmask = 4'b0011; ftags = {6'd0, 6'd0, 6'd41, 6'd40}; #1;
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL short_grant got %b want 0", grant); end
        tick();
        fmask = 4'b0000; ftags = '0;
        checks++; if (count !== 7'd4) begin errors++; $display("FAIL short_free_count got %0d want 4", count); end
        #1;
        checks++; if (grant !== 1'b1) begin errors++; $display("FAIL retry_grant got %b want 1", grant); end
        checks++; if (lane(tags, 0) !== 6'd62) begin errors++; $display("FAIL retry_lane0 got %0d want 62", lane(tags, 0)); end
        checks++; if (lane(tags, 1) !== 6'd63) begin errors++; $display("FAIL retry_lane1 got %0d want 63", lane(tags, 1)); end
        checks++; if (lane(tags, 2) !== 6'd40) begin errors++; $display("FAIL retry_lane2 got %0d want 40", lane(tags, 2)); end
        tick();
        mask = 4'b0001;
        checks++; if (count !== 7'd1) begin errors++; $display("FAIL retry_count got %0d want 1", count); end
        tick();
        mask = 4'b0000; #1;
        checks++; if (grant !== 1'b1) begin errors++; $display("FAIL empty_n0_grant got %b want 1", grant); end
        mask = 4'b0001; #1;
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL empty_n1_grant got %b want 0", grant); end
        tick();
        idle();
        checks++; if (count !== 7'd0) begin errors++; $display("FAIL empty_count got %0d want 0", count); end
    endtask

    task automatic test_checkpoint();
        do_reset();
        valid = 1'b1; mask = 4'b1111;
        repeat (2) tick();
        idle();
        save = 1'b1;
        tick();
        save = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL save_busy got %b want 1", busy); end
        checks++; if (count !== 7'd24) begin errors++; $display("FAIL save_count got %0d want 24", count); end
        valid = 1'b1; mask = 4'b1111; #1;
        checks++; if (lane(tags, 0) !== 6'd40) begin errors++; $display("FAIL spec_lane0 got %0d want 40", lane(tags, 0)); end
        repeat (3) tick();
        idle();
        checks++; if (count !== 7'd12) begin errors++; $display("FAIL spec_count got %0d want 12", count); end
        fmask = 4'b0011; ftags = {6'd0, 6'd0, 6'd41, 6'd40};
        tick();
        idle();
        checks++; if (count !== 7'd14) begin errors++; $display("FAIL busy_free_count got %0d want 14", count); end
        ret = 1'b1; valid = 1'b1; mask = 4'b1111; fmask = 4'b0001; ftags = {6'd0, 6'd0, 6'd0, 6'd45}; #1;
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL return_grant got %b want 0", grant); end
        tick();
        idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL return_busy got %b want 0", busy); end
        checks++; if (count !== 7'd27) begin errors++; $display("FAIL return_count got %0d want 27", count); end
        valid = 1'b1; mask = 4'b0001; #1;
        checks++; if (lane(tags, 0) !== 6'd40) begin errors++; $display("FAIL reissue_lane0 got %0d want 40", lane(tags, 0)); end
        tick();
        // Save in the same cycle as a grant: checkpoint lands after that grant.
        save = 1'b1; mask = 4'b0011;
        tick();
        save = 1'b0; mask = 4'b1111;
        checks++; if (count !== 7'd24) begin errors++; $display("FAIL save_grant_count got %0d want 24", count); end
        tick();
        idle();
        ret = 1'b1;
        tick();
        idle();
        checks++; if (count !== 7'd24) begin errors++; $display("FAIL return2_count got %0d want 24", count); end
        valid = 1'b1; mask = 4'b0001; #1;
        checks++; if (lane(tags, 0) !== 6'd43) begin errors++; $display("FAIL return2_lane0 got %0d want 43", lane(tags, 0)); end
        idle();
    endtask

    task automatic test_wrap();
        do_reset();
        valid = 1'b1; mask = 4'b1111;
        repeat (7) tick();
        mask = 4'b0011;
        tick();
        idle();
        for (int g = 0; g < 7; g++) begin
            fmask = 4'b1111;
            ftags = {6'(35 + 4*g), 6'(34 + 4*g), 6'(33 + 4*g), 6'(32 + 4*g)};
            tick();
        end
        fmask = 4'b0011; ftags = {6'd0, 6'd0, 6'd61, 6'd60};
        tick();
        idle();
        checks++; if (count !== 7'd32) begin errors++; $display("FAIL wrap_fill_count got %0d want 32", count); end
        valid = 1'b1; mask = 4'b1111; #1;
        checks++; if (lane(tags, 0) !== 6'd62) begin errors++; $display("FAIL wrap_lane0 got %0d want 62", lane(tags, 0)); end
        checks++; if (lane(tags, 1) !== 6'd63) begin errors++; $display("FAIL wrap_lane1 got %0d want 63", lane(tags, 1)); end
        checks++; if (lane(tags, 2) !== 6'd32) begin errors++; $display("FAIL wrap_lane2 got %0d want 32", lane(tags, 2)); end
        checks++; if (lane(tags, 3) !== 6'd33) begin errors++; $display("FAIL wrap_lane3 got %0d want 33", lane(tags, 3)); end
        tick();
        mask = 4'b0001; #1;
        checks++; if (lane(tags, 0) !== 6'd34) begin errors++; $display("FAIL wrap_head2_lane0 got %0d want 34", lane(tags, 0)); end
        tick();
        idle();
        checks++; if (count !== 7'd27) begin errors++; $display("FAIL wrap_count got %0d want 27", count); end
    endtask

    task automatic test_err();
        do_reset();
        ret = 1'b1;
        tick();
        idle();
        checks++; if (count !== 7'd32) begin errors++; $display("FAIL idle_return_count got %0d want 32", count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_return_busy got %b want 0", busy); end
        valid = 1'b1; mask = 4'b0001; #1;
        checks++; if (lane(tags, 0) !== 6'd32) begin errors++; $display("FAIL idle_return_head got %0d want 32", lane(tags, 0)); end
        mask = 4'b1111;
        tick();
        idle();
        fmask = 4'b0011; ftags = {6'd0, 6'd0, 6'd32, 6'd5};
        tick();
        idle();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_tag_err got %b want 1", err); end
        checks++; if (count !== 7'd29) begin errors++; $display("FAIL illegal_tag_count got %0d want 29", count); end
        save = 1'b1;
        repeat (3) tick();
        save = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_drop_busy got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_clear_err got %b want 0", err); end
        fmask = 4'b0001; ftags = {6'd0, 6'd0, 6'd0, 6'd33};
        tick();
        idle();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL overflow_err got %b want 1", err); end
        checks++; if (count !== 7'd32) begin errors++; $display("FAIL overflow_count got %0d want 32", count); end
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_alloc();
        test_full();
        test_checkpoint();
        test_wrap();
        test_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
